// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: turns a datapath load/store into a stalled memory handshake.
// Optional alignment check enabled by defining DMC_ALIGN_CHECK_EN.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      r_state, w_state_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic        r_req, w_req_d;
  logic        r_we, w_we_d;
  logic        r_fault, w_fault_d;
  logic [31:0] r_addr, w_addr_d;
  logic [31:0] r_wdata, w_wdata_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic        w_access;
  logic        w_misaligned;

  assign w_access = MemRead | MemWrite;

`ifdef DMC_ALIGN_CHECK_EN
  assign w_misaligned = |ALUResult[1:0];
`else
  logic w_unused_addr_lsb;
  assign w_unused_addr_lsb = ^ALUResult[1:0];
  assign w_misaligned      = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_req_d   = r_req;
    w_we_d    = r_we;
    w_fault_d = 1'b0;
    w_addr_d  = r_addr;
    w_wdata_d = r_wdata;
    w_rdata_d = r_rdata;
    Stall     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_access) begin
          Stall     = 1'b1;
          w_addr_d  = {ALUResult[31:2], 2'b00};
          w_wdata_d = WriteData;
          w_cnt_d   = 8'd0;
          if (w_misaligned) begin
            // Rejected before reaching memory; only a misaligned load clobbers ReadData.
            w_state_d = StDone;
            w_fault_d = 1'b1;
            if (!MemWrite) w_rdata_d = 32'h0;
          end else begin
            w_state_d = StBusy;
            w_req_d   = 1'b1;
            w_we_d    = MemWrite;
          end
        end
      end
      StBusy: begin
        Stall = 1'b1;
        if (mem_ack) begin
          w_state_d = StDone;
          w_req_d   = 1'b0;
          w_we_d    = 1'b0;
          if (!r_we) w_rdata_d = mem_rdata;
        end else if (r_cnt == CntLast) begin
          w_state_d = StDone;
          w_req_d   = 1'b0;
          w_we_d    = 1'b0;
          w_fault_d = 1'b1;
          w_rdata_d = 32'h0;
        end else begin
          w_cnt_d = r_cnt + 8'd1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_req_d   = 1'b0;
        w_we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_fault <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_req   <= w_req_d;
      r_we    <= w_we_d;
      r_fault <= w_fault_d;
      r_addr  <= w_addr_d;
      r_wdata <= w_wdata_d;
      r_rdata <= w_rdata_d;
    end
  end

  assign ReadData  = r_rdata;
  assign Fault     = r_fault;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl with TIMEOUT=4.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, Fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_tests = 0;
  int n_fail  = 0;

  data_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Fault     (Fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
    ALUResult = '0; WriteData = '0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    check("rst_req",   {31'd0, mem_req}, 32'd0);
    check("rst_we",    {31'd0, mem_we}, 32'd0);
    check("rst_fault", {31'd0, Fault}, 32'd0);
    check("rst_addr",  mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_stall", {31'd0, Stall}, 32'd0);
    reset = 1'b0;
    tick();

    // Read with ack on the 2nd BUSY cycle.
    MemRead = 1'b1; ALUResult = 32'h104;
    #1;
    check("rd_idle_stall", {31'd0, Stall}, 32'd1);
    check("rd_idle_req",   {31'd0, mem_req}, 32'd0);
    tick();
    check("rd_b1_req",   {31'd0, mem_req}, 32'd1);
    check("rd_b1_addr",  mem_addr, 32'h104);
    check("rd_b1_we",    {31'd0, mem_we}, 32'd0);
    check("rd_b1_stall", {31'd0, Stall}, 32'd1);
    tick();
    check("rd_b2_req",   {31'd0, mem_req}, 32'd1);
    check("rd_b2_stall", {31'd0, Stall}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0; MemRead = 1'b0;
    #1;
    check("rd_done_rdata", ReadData, 32'hCAFEF00D);
    check("rd_done_fault", {31'd0, Fault}, 32'd0);
    check("rd_done_stall", {31'd0, Stall}, 32'd0);
    check("rd_done_req",   {31'd0, mem_req}, 32'd0);
    tick();
    check("rd_idle_after", {31'd0, Stall}, 32'd0);

    // Write with immediate ack.
    MemWrite = 1'b1; ALUResult = 32'h20; WriteData = 32'h12345678;
    tick();
    check("wr_b1_req",   {31'd0, mem_req}, 32'd1);
    check("wr_b1_we",    {31'd0, mem_we}, 32'd1);
    check("wr_b1_wdata", mem_wdata, 32'h12345678);
    check("wr_b1_addr",  mem_addr, 32'h20);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; MemWrite = 1'b0;
    #1;
    check("wr_done_req",   {31'd0, mem_req}, 32'd0);
    check("wr_done_stall", {31'd0, Stall}, 32'd0);
    check("wr_done_rdata", ReadData, 32'hCAFEF00D);
    check("wr_done_fault", {31'd0, Fault}, 32'd0);
    tick();

    // Ack outside BUSY is ignored.
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_ack = 1'b0;
    check("stray_ack_req",   {31'd0, mem_req}, 32'd0);
    check("stray_ack_rdata", ReadData, 32'hCAFEF00D);

    // Timeout: exactly 4 BUSY cycles then Fault.
    MemRead = 1'b1; ALUResult = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("to_busy%0d_req", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("to_busy%0d_fault", i), {31'd0, Fault}, 32'd0);
    end
    tick();
    MemRead = 1'b0;
    #1;
    check("to_done_fault", {31'd0, Fault}, 32'd1);
    check("to_done_rdata", ReadData, 32'h0);
    check("to_done_req",   {31'd0, mem_req}, 32'd0);
    check("to_done_stall", {31'd0, Stall}, 32'd0);
    tick();
    check("to_fault_pulse", {31'd0, Fault}, 32'd0);

    // Ack collides with timeout in the 4th BUSY cycle: ack wins.
    MemRead = 1'b1; ALUResult = 32'h44;
    tick(); tick(); tick(); tick();
    check("col_b4_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
    tick();
    mem_ack = 1'b0; MemRead = 1'b0;
    #1;
    check("col_rdata", ReadData, 32'hA5A5A5A5);
    check("col_fault", {31'd0, Fault}, 32'd0);
    tick();

    // Reset in the 2nd BUSY cycle aborts without Fault; later ack ignored.
    MemRead = 1'b1; ALUResult = 32'h80;
    tick(); tick();
    check("rst_mid_b2_req", {31'd0, mem_req}, 32'd1);
    MemRead = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_mid_req",   {31'd0, mem_req}, 32'd0);
    check("rst_mid_stall", {31'd0, Stall}, 32'd0);
    check("rst_mid_fault", {31'd0, Fault}, 32'd0);
    check("rst_mid_rdata", ReadData, 32'h0);
    tick();
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_ack = 1'b0;
    check("late_ack_rdata", ReadData, 32'h0);
    check("late_ack_req",   {31'd0, mem_req}, 32'd0);
    check("late_ack_fault", {31'd0, Fault}, 32'd0);

    // Misaligned read at 0x102.
    MemRead = 1'b1; ALUResult = 32'h102;
    tick();
`ifdef DMC_ALIGN_CHECK_EN
    MemRead = 1'b0;
    #1;
    check("mis_req",   {31'd0, mem_req}, 32'd0);
    check("mis_fault", {31'd0, Fault}, 32'd1);
    check("mis_rdata", ReadData, 32'h0);
    check("mis_stall", {31'd0, Stall}, 32'd0);
    tick();
`else
    check("mis_req",  {31'd0, mem_req}, 32'd1);
    check("mis_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_ack = 1'b0; MemRead = 1'b0;
    #1;
    check("mis_rdata", ReadData, 32'h0BADF00D);
    check("mis_fault", {31'd0, Fault}, 32'd0);
    tick();
`endif
    check("end_req", {31'd0, mem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
